// File: rtl/keystream_extractor_if.sv
// Key-byte stream interface: valid/ready byte channel from the keystream
// extractor to the pixel XOR/diffusion stage.
interface keystream_extractor_if;
    logic       m_tvalid;
    logic       m_tready;
    logic [7:0] m_tdata;

    modport master (
        output m_tvalid,
        output m_tdata,
        input  m_tready
    );

    modport slave (
        input  m_tvalid,
        input  m_tdata,
        output m_tready
    );
endinterface

// File: rtl/keystream_extractor.sv
// Keystream extractor: sequences PRNG start and warm-up discard, folds each float32 state
// triple into three key bytes and buffers them in a FIFO feeding a valid/ready byte stream.
// The PRNG cannot be stalled, so triples that do not fit are dropped and flagged (sticky).
// Optional build macro KEYSTREAM_WHITEN_EN folds the exponent field w[30:23] into each key
// byte; it needs PRECISION >= 31.
module keystream_extractor #(
    parameter int unsigned PRECISION  = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DISCARD    = 100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          prng_tvalid,
    input  logic                          prng_valid,
    input  logic [PRECISION-1:0]          prng_x0,
    input  logic [PRECISION-1:0]          prng_x1,
    input  logic [PRECISION-1:0]          prng_x2,
    keystream_extractor_if.master         m_if,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow,
    output logic                          running
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FillW = PtrW + 1;
    localparam int unsigned CntW  = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSeed,
        StWarmup,
        StRun
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           pend_q, pend_d;
    logic [2:0][7:0]      pend_bytes_q, pend_bytes_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FillW-1:0]     fill_q, fill_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           mem_q [FIFO_DEPTH];

    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 take;
    logic                 room;

    // Only the low mantissa bytes (and optionally the exponent) feed the key.
    logic                 unused_bits;
    assign unused_bits = ^{prng_x0, prng_x1, prng_x2};

    function automatic logic [7:0] key_byte(input logic [PRECISION-1:0] w);
`ifdef KEYSTREAM_WHITEN_EN
        return w[7:0] ^ w[15:8] ^ w[30:23];
`else
        return w[7:0] ^ w[15:8];
`endif
    endfunction

    // FSM next state and warm-up counting; start restarts the session from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = StSeed;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StSeed: state_d = (DISCARD == 0) ? StRun : StWarmup;
                StWarmup: begin
                    if (prng_valid) begin
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_q == CntW'(DISCARD - 1)) begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // FIFO, pending-byte shifter and overflow flag next state.
    always_comb begin
        pend_d       = pend_q;
        pend_bytes_d = pend_bytes_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        overflow_d   = overflow_q;

        empty = (fill_q == '0);
        push  = (pend_q != 2'd0) && !start;
        pop   = !empty && m_if.m_tready && !start;
        take  = (state_q == StRun) && prng_valid && !start;
        // Room is judged on the current fill; no pending bytes may be in flight.
        room  = (pend_q == 2'd0) && (fill_q <= FillW'(FIFO_DEPTH - 3));

        if (start) begin
            pend_d     = 2'd0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                pend_d       = pend_q - 2'd1;
                pend_bytes_d = {8'h00, pend_bytes_q[2:1]};
                wr_ptr_d     = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   fill_d = fill_q + FillW'(1);
                2'b01:   fill_d = fill_q - FillW'(1);
                default: fill_d = fill_q;
            endcase
            if (take) begin
                if (room) begin
                    pend_d       = 2'd3;
                    pend_bytes_d = {key_byte(prng_x2), key_byte(prng_x1), key_byte(prng_x0)};
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pend_q       <= 2'd0;
            pend_bytes_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_bytes_q <= pend_bytes_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since fill gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pend_bytes_q[0];
        end
    end

    // Outputs decoded from registered state; head entry falls through when non-empty.
    always_comb begin
        prng_tvalid   = (state_q == StSeed);
        running       = (state_q == StRun);
        m_if.m_tvalid = !empty;
        m_if.m_tdata  = empty ? 8'h00 : mem_q[rd_ptr_q];
        fill          = fill_q;
        overflow      = overflow_q;
    end

endmodule

// File: tb/tb_keystream_extractor.sv
// Bench for keystream_extractor: directed scenarios followed by randomized traffic, all
// compared every cycle against a queue-based transaction model of the extractor.
module tb_keystream_extractor;

    localparam int unsigned Depth   = 4;
    localparam int unsigned Discard = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        prng_valid;
    logic [31:0] x0, x1, x2;
    logic        prng_tvalid;
    logic        running;
    logic        overflow;
    logic [2:0]  fill;

    keystream_extractor_if m_if ();

    keystream_extractor #(
        .PRECISION  (32),
        .FIFO_DEPTH (Depth),
        .DISCARD    (Discard)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .prng_tvalid (prng_tvalid),
        .prng_valid  (prng_valid),
        .prng_x0     (x0),
        .prng_x1     (x1),
        .prng_x2     (x2),
        .m_if        (m_if),
        .fill        (fill),
        .overflow    (overflow),
        .running     (running)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 idle, 1 seed, 2 warm-up, 3 run.
    int         md;
    int         wcnt;
    logic [7:0] mq[$];
    logic [7:0] pq[$];
    bit         movf;

    int         n_pulses;
    logic [7:0] popped[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_key(input logic [31:0] w);
        logic [7:0] k;
        k = w[7:0] ^ w[15:8];
`ifdef KEYSTREAM_WHITEN_EN
        k = k ^ w[30:23];
`endif
        return k;
    endfunction

    task automatic model_reset();
        md   = 0;
        wcnt = 0;
        mq.delete();
        pq.delete();
        movf = 1'b0;
    endtask

    task automatic check_outputs();
        check("prng_tvalid", 32'(prng_tvalid), 32'(md == 1));
        check("running", 32'(running), 32'(md == 3));
        check("m_tvalid", 32'(m_if.m_tvalid), 32'(mq.size() != 0));
        check("m_tdata", 32'(m_if.m_tdata), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check("fill", 32'(fill), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(movf));
        if (prng_tvalid === 1'b1) n_pulses++;
        if (m_if.m_tvalid === 1'b1 && m_if.m_tready === 1'b1) popped.push_back(m_if.m_tdata);
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_step();
        int  fill_now;
        bit  pend_empty;
        if (reset) begin
            model_reset();
        end else if (start) begin
            mq.delete();
            pq.delete();
            movf = 1'b0;
            wcnt = 0;
            md   = 1;
        end else begin
            fill_now   = mq.size();
            pend_empty = (pq.size() == 0);
            if (fill_now != 0 && m_if.m_tready) void'(mq.pop_front());
            if (!pend_empty) mq.push_back(pq.pop_front());
            case (md)
                1: md = (Discard == 0) ? 3 : 2;
                2: if (prng_valid) begin
                    wcnt++;
                    if (wcnt == Discard) md = 3;
                end
                3: if (prng_valid) begin
                    if (pend_empty && (int'(Depth) - fill_now) >= 3) begin
                        pq.push_back(ref_key(x0));
                        pq.push_back(ref_key(x1));
                        pq.push_back(ref_key(x2));
                    end else begin
                        movf = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic st, input logic pv, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic rdy);
        start         = st;
        prng_valid    = pv;
        x0            = a;
        x1            = b;
        x2            = c;
        m_if.m_tready = rdy;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    task automatic rnd_triple(input logic rdy);
        cycle(1'b0, 1'b1, $urandom, $urandom, $urandom, rdy);
    endtask

    logic [7:0] exp_b0, exp_b1, exp_b2;
    logic [7:0] head_exp;

    initial begin
`ifdef KEYSTREAM_WHITEN_EN
        exp_b0 = 8'hE1;
        exp_b1 = 8'h82;
        exp_b2 = 8'h7F;
`else
        exp_b0 = 8'h9F;
        exp_b1 = 8'hFE;
        exp_b2 = 8'h00;
`endif
        reset         = 1'b1;
        start         = 1'b0;
        prng_valid    = 1'b0;
        x0            = '0;
        x1            = '0;
        x2            = '0;
        m_if.m_tready = 1'b0;
        n_pulses      = 0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle: no seed pulse, PRNG data ignored.
        idle(3, 1'b1);
        cycle(1'b0, 1'b1, 32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f, 1'b1);
        idle(2, 1'b1);

        // Start, two warm-up triples, then the reference triple.
        n_pulses = 0;
        popped.delete();
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        idle(2, 1'b1);
        rnd_triple(1'b1);
        idle(2, 1'b1);
        rnd_triple(1'b1);
        check("running_after_warmup", 32'(running), 32'd1);
        cycle(1'b0, 1'b1, 32'h3F1234AB, 32'h3E00FF01, 32'h3F800000, 1'b1);
        idle(6, 1'b1);
        check("seed_pulses", 32'(n_pulses), 32'd1);
        check("pop_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            check("byte0", 32'(popped[0]), 32'(exp_b0));
            check("byte1", 32'(popped[1]), 32'(exp_b1));
            check("byte2", 32'(popped[2]), 32'(exp_b2));
        end

        // Back-pressure: second triple dropped, overflow sticks through the drain.
        rnd_triple(1'b0);
        idle(4, 1'b0);
        rnd_triple(1'b0);
        idle(2, 1'b0);
        check("full_fill", 32'(fill), 32'd3);
        check("full_overflow", 32'(overflow), 32'd1);
        idle(5, 1'b1);
        check("drained_fill", 32'(fill), 32'd0);
        check("drained_overflow", 32'(overflow), 32'd1);

        // Stalled head stays put; restart flushes everything.
        cycle(1'b0, 1'b1, 32'h11223344, 32'h55667788, 32'h99aabbcc, 1'b0);
        head_exp = ref_key(32'h11223344);
        idle(4, 1'b0);
        check("stall_head_0", 32'(m_if.m_tdata), 32'(head_exp));
        idle(3, 1'b0);
        check("stall_head_1", 32'(m_if.m_tdata), 32'(head_exp));
        n_pulses = 0;
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("restart_fill", 32'(fill), 32'd0);
        check("restart_overflow", 32'(overflow), 32'd0);
        idle(2, 1'b0);
        check("restart_pulses", 32'(n_pulses), 32'd1);

        // Asynchronous reset mid-run with data buffered.
        rnd_triple(1'b0);
        rnd_triple(1'b0);
        rnd_triple(1'b0);
        idle(4, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_fill", 32'(fill), 32'd0);
        check("arst_running", 32'(running), 32'd0);
        check("arst_m_tvalid", 32'(m_if.m_tvalid), 32'd0);
        check("arst_m_tdata", 32'(m_if.m_tdata), 32'd0);
        model_reset();
        idle(1, 1'b1);
        reset = 1'b0;
        idle(4, 1'b1);

        // Randomized traffic with occasional restarts.
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 249) == 0), ($urandom_range(0, 2) == 0),
                  $urandom, $urandom, $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
